// File: rtl/bounded_queue_fifo.sv
// bounded_queue_fifo: synchronous bounded FIFO, up to DEPTH words of WIDTH bits.
// Behaves like an SV bounded queue (q[$:DEPTH-1]) in synthesizable form.
// Optional build macro: BQ_STREAM_REVERSE_EN presents the head word bit-reversed
// ({<<{word}}), so stored bit 0 appears on out_data[WIDTH-1].
//
// Handshake: a push occurs on a rising clk edge when in_valid && in_ready, and a
// pop occurs when out_valid && out_ready. in_ready (= !full) and out_valid
// (= !empty) are derived only from the registered count, so neither depends
// combinationally on in_valid or out_ready. A full FIFO refuses a push even when
// a pop happens on the same edge (no bypass). A pushed word reaches out_data one
// cycle after its push edge (no fall-through). flush clears pointers and count
// and overrides any push or pop on that edge.
module bounded_queue_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 11,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head;

   // Pointers wrap DEPTH-1 -> 0 explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Occupancy state: pointers and count; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= in_data;
   end

   // Head word, forced to zero while empty, optionally bit-reversed.
   always_comb begin
      head     = mem[rd_ptr];
      out_data = '0;
      if (!empty) begin
`ifdef BQ_STREAM_REVERSE_EN
         for (int i = 0; i < WIDTH; i++) out_data[WIDTH-1-i] = head[i];
`else
         out_data = head;
`endif
      end
   end

endmodule

// File: tb/tb_bounded_queue_fifo.sv
// tb_bounded_queue_fifo: randomized stimulus against a queue-based reference model.
module tb_bounded_queue_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 11;
   localparam int CW    = $clog2(DEPTH + 1);

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   always #5 clk = ~clk;

   bounded_queue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .empty(empty)
   );

   // ---------------- scoreboard ----------------
   logic [WIDTH-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   // Expected presentation of the head element.
   function automatic logic [WIDTH-1:0] exp_head();
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] r;
      if (exp_q.size() == 0) return '0;
      w = exp_q[0];
`ifdef BQ_STREAM_REVERSE_EN
      for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = w[i];
`else
      r = w;
`endif
      return r;
   endfunction

   // ---------------- driver ----------------
   // Called right after a falling edge; returns right after the next falling edge.
   task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d,
                              input logic r, input logic f);
      bit do_push;
      bit do_pop;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      do_push   = v && (exp_q.size() < DEPTH);
      do_pop    = r && (exp_q.size() > 0);
      @(posedge clk);
      if (f) begin
         exp_q.delete();
      end else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(d);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 ||
          out_valid !== 1'b0 || out_data !== '0) begin
         bad++;
         $display("FAIL reset got count=%0d empty=%b full=%b in_ready=%b out_valid=%b out_data=%h expected 0 1 0 1 0 0",
                  count, empty, full, in_ready, out_valid, out_data);
      end
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
      total++;
      if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
         bad++;
         $display("FAIL fill_full got full=%b in_ready=%b count=%0d expected 1 0 %0d",
                  full, in_ready, count, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (out_data !== exp_head() || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_data[%0d] got %h valid=%b expected %h", i, out_data, out_valid, exp_head());
         end
         drive_cycle(1'b0, '0, 1'b1, 1'b0);
      end
      total++;
      if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
         bad++;
         $display("FAIL drain_empty got empty=%b out_valid=%b out_data=%h expected 1 0 0",
                  empty, out_valid, out_data);
      end
   endtask

   task automatic test_wrap();
      int n_seq[4] = '{8, 8, 11, 11};
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < n_seq[ph]; i++) begin
            if (ph % 2 == 1) begin
               total++;
               if (out_data !== exp_head()) begin
                  bad++;
                  $display("FAIL wrap_data ph=%0d i=%0d got %h expected %h", ph, i, out_data, exp_head());
               end
            end
            drive_cycle(ph % 2 == 0, $urandom, ph % 2 == 1, 1'b0);
            total++;
            if (count !== CW'(exp_q.size()) || count > CW'(DEPTH)) begin
               bad++;
               $display("FAIL wrap_count ph=%0d got %0d expected %0d", ph, count, exp_q.size());
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         total++;
         if (out_data !== exp_head()) begin
            bad++;
            $display("FAIL simul_data[%0d] got %h expected %h", i, out_data, exp_head());
         end
         drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
         total++;
         if (count !== CW'(5)) begin
            bad++;
            $display("FAIL simul_count[%0d] got %0d expected 5", i, count);
         end
      end
      while (exp_q.size() > 0) drive_cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_full_pop();
      logic [WIDTH-1:0] rejected;
      while (exp_q.size() < DEPTH) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      rejected = 32'hDEAD_0001;
      drive_cycle(1'b1, rejected, 1'b1, 1'b0);
      total++;
      if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL fullpop_reject got count=%0d in_ready=%b expected %0d 1", count, in_ready, DEPTH - 1);
      end
      drive_cycle(1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
      total++;
      if (count !== CW'(DEPTH) || full !== 1'b1) begin
         bad++;
         $display("FAIL fullpop_accept got count=%0d full=%b expected %0d 1", count, full, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (out_data !== exp_head()) begin
            bad++;
            $display("FAIL fullpop_drain[%0d] got %h expected %h", i, out_data, exp_head());
         end
         drive_cycle(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_flush();
      while (exp_q.size() < 7) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hF1F1_F1F1, 1'b1, 1'b1);
      total++;
      if (count !== '0 || empty !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
         bad++;
         $display("FAIL flush_clear got count=%0d empty=%b out_valid=%b out_data=%h expected 0 1 0 0",
                  count, empty, out_valid, out_data);
      end
      drive_cycle(1'b1, 32'h0000_0001, 1'b0, 1'b0);
      total++;
`ifdef BQ_STREAM_REVERSE_EN
      if (out_data !== 32'h8000_0000 || count !== CW'(1)) begin
`else
      if (out_data !== 32'h0000_0001 || count !== CW'(1)) begin
`endif
         bad++;
         $display("FAIL flush_next got out_data=%h count=%0d expected head %h count 1", out_data, count, exp_head());
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      total++;
      if (count !== '0 || empty !== 1'b1 || out_data !== '0) begin
         bad++;
         $display("FAIL midreset got count=%0d empty=%b out_data=%h expected 0 1 0", count, empty, out_data);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_release got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         total++;
         if (out_data !== exp_head() || out_valid !== (exp_q.size() > 0) ||
             in_ready !== (exp_q.size() < DEPTH)) begin
            bad++;
            $display("FAIL rand_head[%0d] got data=%h ov=%b ir=%b expected %h %b %b", i, out_data,
                     out_valid, in_ready, exp_head(), exp_q.size() > 0, exp_q.size() < DEPTH);
         end
         drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 49) == 0);
         total++;
         if (count !== CW'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
             empty !== (exp_q.size() == 0)) begin
            bad++;
            $display("FAIL rand_count[%0d] got count=%0d full=%b empty=%b expected %0d", i,
                     count, full, empty, exp_q.size());
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_full_pop();
      test_flush();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
